// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register: mode and burst-state
// encodings, plus the test for modes that a burst may repeat.
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        SHR   = 3'd1,
        SHL   = 3'd2,
        LOAD  = 3'd3,
        ROR   = 3'd4,
        ROL   = 3'd5,
        ASR   = 3'd6,
        HOLD7 = 3'd7
    } usr_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } usr_state_t;

    // Hold and load are not meaningful to repeat, so they never start a burst.
    function automatic logic is_shift_mode(input usr_mode_t mode);
        return (mode == SHR) || (mode == SHL) || (mode == ROR) ||
               (mode == ROL) || (mode == ASR);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step next-value function of the shift register; the one
// place where the meaning of every mode is defined.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  usr_mode_t        mode_i,
    input  logic             sl_i,
    input  logic             sr_i,
    input  logic [WIDTH-1:0] par_in_i,
    output logic [WIDTH-1:0] q_o
);

    always_comb begin
        q_o = q_i;
        case (mode_i)
            SHR:     q_o = {sl_i, q_i[WIDTH-1:1]};
            SHL:     q_o = {q_i[WIDTH-2:0], sr_i};
            LOAD:    q_o = par_in_i;
            ROR:     q_o = {q_i[0], q_i[WIDTH-1:1]};
            ROL:     q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            ASR:     q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default: q_o = q_i;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register, updated on the falling clock edge.
// Define USR_BURST_EN to build the multi-position burst engine (start/shamt/busy/done).
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       m,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] par_out,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    generate
        if (WIDTH < 2) begin : g_width_chk
            $error("univ_shift_reg: WIDTH must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] q_q, q_d;
    usr_mode_t        m_mode;
    usr_mode_t        step_mode;

    assign m_mode = usr_mode_t'(m);

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i      (q_q),
        .mode_i   (step_mode),
        .sl_i     (sl),
        .sr_i     (sr),
        .par_in_i (par_in),
        .q_o      (q_d)
    );

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

`ifdef USR_BURST_EN
    usr_state_t       state_q, state_d;
    usr_mode_t        bmode_q, bmode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bmode_q <= HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bmode_q <= bmode_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bmode_d   = bmode_q;
        cnt_d     = cnt_q;
        step_mode = m_mode;
        case (state_q)
            IDLE: begin
                // The accepting edge only latches the request; shifting starts next edge.
                if (start && is_shift_mode(m_mode)) begin
                    bmode_d   = m_mode;
                    cnt_d     = shamt;
                    step_mode = HOLD;
                    state_d   = (shamt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                step_mode = bmode_q;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                step_mode = HOLD;
                state_d   = IDLE;
            end
            default: begin
                step_mode = HOLD;
                state_d   = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
`else
    logic unused_burst_inputs;

    assign unused_burst_inputs = ^{start, shamt};
    assign step_mode           = m_mode;
    assign busy                = 1'b0;
    assign done                = 1'b0;
`endif

    assign par_out = q_q;
    assign so_msb  = q_q[WIDTH-1];
    assign so_lsb  = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8; burst scenarios are
// exercised when USR_BURST_EN is defined, the plain-shift fallback otherwise.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] m;
    logic       sl;
    logic       sr;
    logic [7:0] par_in;
    logic       start;
    logic [3:0] shamt;
    logic [7:0] par_out;
    logic       so_msb;
    logic       so_lsb;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m       (m),
        .sl      (sl),
        .sr      (sr),
        .par_in  (par_in),
        .start   (start),
        .shamt   (shamt),
        .par_out (par_out),
        .so_msb  (so_msb),
        .so_lsb  (so_lsb),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0h ok", tag, got);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One active (falling) edge, then return on the rising edge, away from it.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        m      = 3'd3;
        par_in = v;
        start  = 1'b0;
        tick();
        m = 3'd0;
    endtask

    task automatic direct(input string tag, input logic [2:0] mode, input logic s_l,
                          input logic s_r, input logic [7:0] exp);
        load(8'hA5);
        m  = mode;
        sl = s_l;
        sr = s_r;
        tick();
        m = 3'd0;
        check(tag, {24'd0, par_out}, {24'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; m = 3'd0; sl = 1'b0; sr = 1'b0;
        par_in = 8'h00; start = 1'b0; shamt = 4'd0;
        @(posedge clk);

        m = 3'd3; par_in = 8'hA5;
        tick();
        check("rst_q", {24'd0, par_out}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        tick();
        check("rst_q2", {24'd0, par_out}, 32'h00);

        rst_n = 1'b1;
        tick();
        check("load_a5", {24'd0, par_out}, 32'hA5);
        check("so_msb", {31'd0, so_msb}, 32'd1);
        check("so_lsb", {31'd0, so_lsb}, 32'd1);

        direct("shr_sl0", 3'd1, 1'b0, 1'b0, 8'h52);
        check("so_lsb_52", {31'd0, so_lsb}, 32'd0);
        direct("shr_sl1", 3'd1, 1'b1, 1'b0, 8'hD2);
        direct("shl_sr1", 3'd2, 1'b0, 1'b1, 8'h4B);
        direct("shl_sr0", 3'd2, 1'b0, 1'b0, 8'h4A);
        direct("ror", 3'd4, 1'b0, 1'b0, 8'hD2);
        direct("rol", 3'd5, 1'b0, 1'b0, 8'h4B);
        direct("asr", 3'd6, 1'b0, 1'b0, 8'hD2);
        direct("hold7", 3'd7, 1'b1, 1'b1, 8'hA5);
        direct("hold0", 3'd0, 1'b1, 1'b1, 8'hA5);
        sl = 1'b0; sr = 1'b0;

`ifdef USR_BURST_EN
        // Burst: rotate-left 3 from 81.
        load(8'h81);
        m = 3'd5; start = 1'b1; shamt = 4'd3;
        tick();
        check("b_start_q", {24'd0, par_out}, 32'h81);
        check("b_start_busy", {31'd0, busy}, 32'd1);
        start = 1'b0; m = 3'd0;
        tick();
        check("b_e1", {24'd0, par_out}, 32'h03);
        check("b_e1_done", {31'd0, done}, 32'd0);
        tick();
        check("b_e2", {24'd0, par_out}, 32'h06);
        tick();
        check("b_e3", {24'd0, par_out}, 32'h0C);
        check("b_done", {31'd0, done}, 32'd1);
        check("b_done_busy", {31'd0, busy}, 32'd1);
        tick();
        check("b_idle_q", {24'd0, par_out}, 32'h0C);
        check("b_idle_busy", {31'd0, busy}, 32'd0);
        check("b_idle_done", {31'd0, done}, 32'd0);

        // Zero-length burst.
        load(8'h3C);
        m = 3'd1; start = 1'b1; shamt = 4'd0;
        tick();
        start = 1'b0; m = 3'd0;
        check("z_q", {24'd0, par_out}, 32'h3C);
        check("z_done", {31'd0, done}, 32'd1);
        tick();
        check("z_idle", {31'd0, busy}, 32'd0);

        // Over-length plain shift saturates.
        load(8'hFF);
        m = 3'd1; sl = 1'b0; start = 1'b1; shamt = 4'd12;
        tick();
        start = 1'b0; m = 3'd0;
        for (int i = 0; i < 11; i++) tick();
        check("s12_pre_done", {31'd0, done}, 32'd0);
        tick();
        check("s12_shr", {24'd0, par_out}, 32'h00);
        check("s12_done", {31'd0, done}, 32'd1);
        tick();

        // Over-length rotate wraps.
        load(8'h01);
        m = 3'd4; start = 1'b1; shamt = 4'd12;
        tick();
        start = 1'b0; m = 3'd0;
        for (int i = 0; i < 12; i++) tick();
        check("s12_ror", {24'd0, par_out}, 32'h10);
        tick();

        // A start while busy is ignored.
        load(8'h01);
        m = 3'd2; sr = 1'b0; start = 1'b1; shamt = 4'd2;
        tick();
        m = 3'd1; shamt = 4'd5; par_in = 8'hFF;
        tick();
        check("ign_e1", {24'd0, par_out}, 32'h02);
        tick();
        check("ign_e2", {24'd0, par_out}, 32'h04);
        check("ign_done", {31'd0, done}, 32'd1);
        tick();
        start = 1'b0; m = 3'd0;
        check("ign_idle_q", {24'd0, par_out}, 32'h04);
        check("ign_idle_busy", {31'd0, busy}, 32'd0);

        // Reset abandons a burst without a done pulse.
        load(8'h81);
        m = 3'd5; start = 1'b1; shamt = 4'd3;
        tick();
        start = 1'b0; m = 3'd0;
        tick();
        check("r_e1", {24'd0, par_out}, 32'h03);
        rst_n = 1'b0;
        tick();
        check("r_q", {24'd0, par_out}, 32'h00);
        check("r_busy", {31'd0, busy}, 32'd0);
        check("r_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("r_done2", {31'd0, done}, 32'd0);
        tick();
        check("r_done3", {31'd0, done}, 32'd0);
        check("r_q3", {24'd0, par_out}, 32'h00);
`else
        // Without the burst engine, start is ignored and m shifts every edge.
        load(8'hA5);
        m = 3'd1; sl = 1'b0; start = 1'b1; shamt = 4'd3;
        tick();
        check("nb_e1", {24'd0, par_out}, 32'h52);
        check("nb_busy1", {31'd0, busy}, 32'd0);
        tick();
        check("nb_e2", {24'd0, par_out}, 32'h29);
        check("nb_done2", {31'd0, done}, 32'd0);
        tick();
        check("nb_e3", {24'd0, par_out}, 32'h14);
        tick();
        check("nb_e4", {24'd0, par_out}, 32'h0A);
        check("nb_busy4", {31'd0, busy}, 32'd0);
        check("nb_done4", {31'd0, done}, 32'd0);
        start = 1'b0; m = 3'd0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
